// File: rtl/ctrl_pkg.sv
// Shared types and control-word field layout for the issue sequencer.
// Field LSB/width constants cover every control-word field, including ones the sequencer never reads.
package ctrl_pkg;

    localparam int unsigned CW_W        = 33;
    localparam int unsigned MEM_TIMEOUT = 15;

    localparam int unsigned ALU_OP_LSB        = 29;
    localparam int unsigned ALU_OP_W          = 4;
    localparam int unsigned ALU_REG1_LSB      = 26;
    localparam int unsigned ALU_REG1_W        = 3;
    localparam int unsigned ALU_REG2_LSB      = 23;
    localparam int unsigned ALU_REG2_W        = 3;
    localparam int unsigned ALU_OP_SRC1_LSB   = 21;
    localparam int unsigned ALU_OP_SRC1_W     = 2;
    localparam int unsigned ALU_OP_SRC2_LSB   = 19;
    localparam int unsigned ALU_OP_SRC2_W     = 2;
    localparam int unsigned ALU_DEST_LSB      = 18;
    localparam int unsigned ALU_DEST_W        = 1;
    localparam int unsigned REG_DEST_LSB      = 15;
    localparam int unsigned REG_DEST_W        = 3;
    localparam int unsigned REG_SET_H_LSB     = 14;
    localparam int unsigned REG_SET_H_W       = 1;
    localparam int unsigned REG_SET_L_LSB     = 13;
    localparam int unsigned REG_SET_L_W       = 1;
    localparam int unsigned REG_ADDR_LSB      = 10;
    localparam int unsigned REG_ADDR_W        = 3;
    localparam int unsigned MEM_READ_B_LSB    = 9;
    localparam int unsigned MEM_READ_B_W      = 1;
    localparam int unsigned MEM_READ_W_LSB    = 8;
    localparam int unsigned MEM_READ_W_W      = 1;
    localparam int unsigned MEM_WRITE_B_LSB   = 7;
    localparam int unsigned MEM_WRITE_B_W     = 1;
    localparam int unsigned MEM_WRITE_W_LSB   = 6;
    localparam int unsigned MEM_WRITE_W_W     = 1;
    localparam int unsigned SET_REG_COND_LSB  = 0;
    localparam int unsigned SET_REG_COND_W    = 6;

    typedef enum logic [1:0] {IDLE, MEM_LO, MEM_HI, EXEC} seq_state_e;

    typedef enum logic [2:0] {NONE, RD_B, RD_W, WR_B, WR_W} acc_e;

    // Highest-priority access wins when several memory bits are set.
    function automatic acc_e sel_access(input logic [CW_W-1:0] cw);
        if (cw[MEM_READ_W_LSB])       return RD_W;
        else if (cw[MEM_READ_B_LSB])  return RD_B;
        else if (cw[MEM_WRITE_W_LSB]) return WR_W;
        else if (cw[MEM_WRITE_B_LSB]) return WR_B;
        else                          return NONE;
    endfunction

    function automatic logic mem_conflict(input logic [CW_W-1:0] cw);
        logic [3:0] bits;
        bits = {cw[MEM_READ_B_LSB], cw[MEM_READ_W_LSB], cw[MEM_WRITE_B_LSB], cw[MEM_WRITE_W_LSB]};
        return $countones(bits) > 1;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Decoder handshake, datapath commit and byte-bus signals of the issue sequencer.
interface ctrl_sequencer_if;
    import ctrl_pkg::*;

    logic [CW_W-1:0] cw_in;
    logic            cw_valid;
    logic            cw_ready;
    logic [CW_W-1:0] exec_cw;
    logic            exec_en;
    logic            cw_illegal;
    logic            mem_req;
    logic            mem_we;
    logic            mem_hi;
    logic            mem_ack;
    logic            mem_timeout;
    logic            busy;

    modport slave (
        input  cw_in, cw_valid, mem_ack,
        output cw_ready, exec_cw, exec_en, cw_illegal, mem_req, mem_we, mem_hi,
               mem_timeout, busy
    );

    modport master (
        output cw_in, cw_valid, mem_ack,
        input  cw_ready, exec_cw, exec_en, cw_illegal, mem_req, mem_we, mem_hi,
               mem_timeout, busy
    );

endinterface

// File: rtl/ctrl_seq_timer.sv
// Bus-phase watchdog: counts unacknowledged request cycles, flags the last allowed one.
module ctrl_seq_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned Timeout = MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic expire
);
    localparam int unsigned CntW = $clog2(Timeout + 1);

    logic [CntW-1:0] cnt_q;

    // Any non-counting cycle is either idle or an ack, i.e. a phase boundary.
    always_ff @(posedge clk) begin
        if (rst || !inc) cnt_q <= '0;
        else             cnt_q <= cnt_q + 1'b1;
    end

    assign expire = inc && (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle issue controller: latches a control word, runs its byte-bus phases, then commits.
// Optional bus-phase timeout enabled by defining CTRL_SEQ_TIMEOUT_EN.
module ctrl_sequencer
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    ctrl_sequencer_if.slave  bus
);
    seq_state_e      state_q;
    acc_e            acc_q;
    logic            illegal_q;
    logic [CW_W-1:0] exec_cw_q;
    logic            exec_en_q, cw_illegal_q, mem_req_q, mem_we_q, mem_hi_q, mem_timeout_q;
    logic            tmo_expire;
    acc_e            acc_new;

    assign acc_new = sel_access(bus.cw_in);

`ifdef CTRL_SEQ_TIMEOUT_EN
    ctrl_seq_timer #(
        .Timeout (MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .inc    (mem_req_q && !bus.mem_ack),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= NONE;
            illegal_q     <= 1'b0;
            exec_cw_q     <= '0;
            exec_en_q     <= 1'b0;
            cw_illegal_q  <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_hi_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            exec_en_q     <= 1'b0;
            cw_illegal_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cw_valid) begin
                        exec_cw_q <= bus.cw_in;
                        acc_q     <= acc_new;
                        illegal_q <= mem_conflict(bus.cw_in);
                        if (acc_new == NONE) begin
                            state_q   <= EXEC;
                            exec_en_q <= 1'b1;
                        end else begin
                            state_q   <= MEM_LO;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= (acc_new == WR_B) || (acc_new == WR_W);
                            mem_hi_q  <= 1'b0;
                        end
                    end
                end
                MEM_LO, MEM_HI: begin
                    if (bus.mem_ack) begin
                        if (state_q == MEM_LO && (acc_q == RD_W || acc_q == WR_W)) begin
                            state_q  <= MEM_HI;
                            mem_hi_q <= 1'b1;
                        end else begin
                            state_q      <= EXEC;
                            mem_req_q    <= 1'b0;
                            mem_we_q     <= 1'b0;
                            mem_hi_q     <= 1'b0;
                            exec_en_q    <= 1'b1;
                            cw_illegal_q <= illegal_q;
                        end
                    end else if (tmo_expire) begin
                        state_q       <= IDLE;
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        mem_hi_q      <= 1'b0;
                        mem_timeout_q <= 1'b1;
                    end
                end
                EXEC: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cw_ready    = (state_q == IDLE) && !rst;
    assign bus.busy        = (state_q != IDLE);
    assign bus.exec_cw     = exec_cw_q;
    assign bus.exec_en     = exec_en_q;
    assign bus.cw_illegal  = cw_illegal_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_hi      = mem_hi_q;
    assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; timeout scenario follows CTRL_SEQ_TIMEOUT_EN.
module tb_ctrl_sequencer;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    ctrl_sequencer_if bus ();

    ctrl_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle, so checks sample mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [CW_W-1:0] cw);
        bus.cw_in    = cw;
        bus.cw_valid = 1'b1;
        step();
        bus.cw_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        bus.cw_in    = '0;
        bus.cw_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        step();
        step();
        check("rst_ready", bus.cw_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_exec_cw", bus.exec_cw, 0);
        check("rst_exec_en", bus.exec_en, 0);
        check("rst_timeout", bus.mem_timeout, 0);
        rst = 1'b0;
        #1;
        check("idle_ready", bus.cw_ready, 1);

        // Non-memory word commits in the cycle right after accept.
        accept(33'h1_2345_6000);
        check("nm_exec_en", bus.exec_en, 1);
        check("nm_req", bus.mem_req, 0);
        check("nm_exec_cw", bus.exec_cw, 64'h1_2345_6000);
        check("nm_ready_busy", bus.cw_ready, 0);
        check("nm_illegal", bus.cw_illegal, 0);
        step();
        check("nm_exec_en_drop", bus.exec_en, 0);
        check("nm_ready_again", bus.cw_ready, 1);

        // Word read, ack in third cycle of each phase.
        accept(33'h0_0000_0100);
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 3; i++) begin
                check("rw_req", bus.mem_req, 1);
                check("rw_hi", bus.mem_hi, ph);
                check("rw_we", bus.mem_we, 0);
                check("rw_no_exec", bus.exec_en, 0);
                if (i == 2) bus.mem_ack = 1'b1;
                step();
                bus.mem_ack = 1'b0;
            end
        end
        check("rw_exec_en", bus.exec_en, 1);
        check("rw_req_drop", bus.mem_req, 0);
        step();
        check("rw_single_exec", bus.exec_en, 0);
        check("rw_idle", bus.busy, 0);

        // Byte write, immediate ack.
        accept(33'h1_0000_0080);
        check("wb_req", bus.mem_req, 1);
        check("wb_we", bus.mem_we, 1);
        check("wb_hi", bus.mem_hi, 0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("wb_exec_en", bus.exec_en, 1);
        check("wb_no_hi_phase", bus.mem_req, 0);
        step();
        check("wb_idle", bus.busy, 0);

        // Conflicting memReadB + memWriteW resolves to a byte read, flagged illegal.
        accept(33'h0_0000_0240);
        check("cf_we", bus.mem_we, 0);
        check("cf_hi", bus.mem_hi, 0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("cf_exec_en", bus.exec_en, 1);
        check("cf_illegal", bus.cw_illegal, 1);
        check("cf_single_phase", bus.mem_req, 0);
        step();
        check("cf_illegal_drop", bus.cw_illegal, 0);

        // Stray ack while idle is ignored.
        bus.mem_ack = 1'b1;
        step();
        step();
        bus.mem_ack = 1'b0;
        check("stray_busy", bus.busy, 0);
        check("stray_req", bus.mem_req, 0);
        check("stray_exec_en", bus.exec_en, 0);
        check("stray_exec_cw", bus.exec_cw, 64'h0_0000_0240);

        // cw_valid during MEM_LO is ignored; reset in MEM_HI aborts cleanly.
        accept(33'h0_1234_0100);
        bus.cw_in    = 33'h1_FFFF_0000;
        bus.cw_valid = 1'b1;
        step();
        step();
        bus.cw_valid = 1'b0;
        check("lo_exec_cw_hold", bus.exec_cw, 64'h0_1234_0100);
        check("lo_req_hold", bus.mem_req, 1);
        check("lo_hi_hold", bus.mem_hi, 0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("hi_phase", bus.mem_hi, 1);
        rst = 1'b1;
        step();
        check("rst_mid_req", bus.mem_req, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_exec_en", bus.exec_en, 0);
        rst = 1'b0;
        step();
        check("rst_mid_no_exec", bus.exec_en, 0);
        check("rst_mid_exec_cw", bus.exec_cw, 0);

        // Never-acknowledged byte write.
        accept(33'h0_0000_0080);
`ifdef CTRL_SEQ_TIMEOUT_EN
        n = 0;
        while (bus.mem_req && n < 40) begin
            check("to_no_exec", bus.exec_en, 0);
            n++;
            step();
        end
        check("to_req_cycles", n, MEM_TIMEOUT);
        check("to_pulse", bus.mem_timeout, 1);
        check("to_exec_en", bus.exec_en, 0);
        check("to_idle", bus.busy, 0);
        step();
        check("to_pulse_drop", bus.mem_timeout, 0);
        check("to_still_no_exec", bus.exec_en, 0);
`else
        n = 0;
        repeat (100) begin
            if (bus.exec_en || bus.mem_timeout) n++;
            step();
        end
        check("nto_req_held", bus.mem_req, 1);
        check("nto_timeout", bus.mem_timeout, 0);
        check("nto_no_exec_or_tmo", n, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("nto_reset_clears", bus.mem_req, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Multi-cycle issue controller between the instruction decoder and the datapath. It accepts one 33-bit control word per valid/ready handshake and holds it stable for the datapath. It splits the word's memory access into byte-wide bus transactions: one for byte ops, two (low then high) for word ops. It then emits a single commit strobe, which is the only point at which the datapath may update registers, PC and flags.

Parameters:
CW_W, 33, control word width; fixed field layout below.
MEM_TIMEOUT, 15, max cycles a bus phase may wait for mem_ack (only with CTRL_SEQ_TIMEOUT_EN).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
cw_in  in  CW_W  control word from the decoder.
cw_valid  in  1  cw_in is valid.
cw_ready  out  1  sequencer can accept a word.
exec_cw  out  CW_W  latched word, stable from accept until the next accept.
exec_en  out  1  one-cycle commit strobe to the datapath.
cw_illegal  out  1  pulses with exec_en when the word had conflicting memory bits.
mem_req  out  1  bus request; held until acknowledged.
mem_we  out  1  1 = write transaction.
mem_hi  out  1  byte lane: 0 = low byte (addr), 1 = high byte (addr+1).
mem_ack  in  1  bus completion; sampled only while mem_req=1.
mem_timeout  out  1  one-cycle pulse when a bus phase is aborted.
busy  out  1  state != IDLE.

Behaviour:
- Field bit positions (MSB first): aluOp[32:29], aluReg1[28:26], aluReg2[25:23], aluOpSource1[22:21], aluOpSource2[20:19], aluDest[18], regDest[17:15], regSetH[14], regSetL[13], regAddr[12:10], memReadB[9], memReadW[8], memWriteB[7], memWriteW[6], setRegCond[5:0].
- States: IDLE, MEM_LO, MEM_HI, EXEC.
- Reset: state=IDLE; exec_cw=0; exec_en, cw_illegal, mem_req, mem_we, mem_hi, mem_timeout, busy all 0. cw_ready=0 while rst=1.
- cw_ready = (state==IDLE) && !rst. Accept happens on cw_valid && cw_ready. cw_valid in any other state is ignored; the decoder must hold the word.
- On accept: latch cw_in into exec_cw and select the access. Priority is memReadW > memReadB > memWriteW > memWriteB. The illegal flag is set if more than one mem bit is set. With no mem bit set, next state is EXEC; otherwise next state is MEM_LO.
- MEM_LO: mem_req=1, mem_hi=0, mem_we=(selected access is a write). On mem_ack, go to MEM_HI for word accesses and to EXEC for byte accesses. Otherwise hold.
- MEM_HI: mem_req=1, mem_hi=1, same mem_we. On mem_ack, go to EXEC.
- mem_req, mem_we and mem_hi are registered. They are stable throughout a phase and drop in the cycle after the ack edge.
- EXEC: exec_en=1 for exactly one cycle, with cw_illegal=illegal flag. Next state is IDLE.
- Latency (accept at edge N, mem_ack combinational same cycle as mem_req):
  - non-memory word: exec_en high in cycle N+1.
  - byte access, ack in first cycle of request: exec_en in N+2.
  - word access, ack in first cycle of each phase: exec_en in N+3.
  - next accept is possible one cycle after exec_en.
- mem_ack while mem_req=0 is ignored and must not advance state.
- rst asserted mid-transaction overrides everything: next cycle is IDLE with mem_req=0 and no exec_en. The bus owner must discard the outstanding request.

Optional Feature:
- Macro: CTRL_SEQ_TIMEOUT_EN.
- Defined: a cycle counter of width clog2(MEM_TIMEOUT+1) clears on each phase entry and increments every cycle mem_req=1 && !mem_ack. When it reaches MEM_TIMEOUT with no ack:
  - drop mem_req;
  - pulse mem_timeout;
  - go to IDLE without exec_en.
- Undefined: no counter; phases wait indefinitely; mem_timeout tied 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - CW_W;
  - field LSB/width constants for every field listed above;
  - the state enum (IDLE, MEM_LO, MEM_HI, EXEC);
  - access-kind enum (NONE, RD_B, RD_W, WR_B, WR_W).
- Field extraction reuses the existing ctrl_decode instance on exec_cw; no new decoder.
- One natural sub-module, ctrl_seq_timer: the timeout counter, instantiated only under CTRL_SEQ_TIMEOUT_EN.

Test Plan:
- Non-memory word: cw_in=0x1_2345_6000 (mem bits 0) accepted at edge N → exec_en=1 only in cycle N+1, mem_req never asserted, exec_cw=0x1_2345_6000, cw_ready=1 in N+2.
- memReadW (bit 8), mem_ack delayed 3 cycles per phase → MEM_LO held 3 cycles with mem_hi=0 mem_we=0, then MEM_HI 3 cycles with mem_hi=1, then exactly one exec_en.
- memWriteB (bit 7) with immediate ack → one request with mem_we=1 mem_hi=0, exec_en at N+2, no MEM_HI.
- Conflicting bits 9 and 6 → treated as byte read (mem_we=0, single phase), cw_illegal=1 coincident with exec_en.
- Stray mem_ack in IDLE and cw_valid pulses during MEM_LO → no state change, exec_cw unchanged; rst in MEM_HI → mem_req=0, busy=0 next cycle, no exec_en.
- CTRL_SEQ_TIMEOUT_EN, MEM_TIMEOUT=15, mem_ack never asserted → mem_timeout pulses after 15 request cycles, then IDLE with no exec_en; without the macro, mem_req is still high after 100 cycles.
